// File: rtl/ahb_slave_responder_if.sv
// AHB-Lite slave-side bus bundle: address/data phase inputs plus slave response outputs.
interface ahb_slave_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    hselx;
  logic [ADDR_WIDTH-1:0]   haddr;
  logic [1:0]              htrans;
  logic                    hwrite;
  logic [2:0]              hsize;
  logic [2:0]              hburst;
  logic                    hready;
  logic [DATA_WIDTH-1:0]   hwdata;
  logic [DATA_WIDTH/8-1:0] hwstrb;
  logic                    hreadyout;
  logic [DATA_WIDTH-1:0]   hrdata;
  logic                    hresp;

  modport master (
    output hselx, haddr, htrans, hwrite, hsize, hburst, hready, hwdata, hwstrb,
    input  hreadyout, hrdata, hresp
  );

  modport slave (
    input  hselx, haddr, htrans, hwrite, hsize, hburst, hready, hwdata, hwstrb,
    output hreadyout, hrdata, hresp
  );
endinterface

// File: rtl/ahb_slave_responder.sv
// AHB-Lite memory-backed slave responder with programmable wait states and a
// two-cycle ERROR response.
module ahb_slave_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                  hclk,
  input logic                  hresetn,
  ahb_slave_responder_if.slave bus
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned LaneBits = $clog2(NumBytes);
  localparam int unsigned WordBits = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [WordBits-1:0]   word_q, word_d;
  logic                  write_q, write_d;
  logic [NumBytes-1:0]   win_q, win_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  ready_state;
  logic                  accept;
  logic                  req_err;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] req_word_full;
  logic [WordBits-1:0]   req_word;
  logic [NumBytes-1:0]   req_win;
  logic [LaneBits-1:0]   req_off;
  logic [LaneBits-1:0]   size_mask;
  logic [WordBits-1:0]   rd_idx;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  state_e                ok_dest;

  // Address-phase decode of the transfer currently on the bus.
  always_comb begin
    req_word_full = bus.haddr >> LaneBits;
    req_word      = req_word_full[WordBits-1:0];
    req_off       = bus.haddr[LaneBits-1:0];
    size_mask     = LaneBits'((32'd1 << bus.hsize) - 32'd1);
    req_err       = 1'b0;
    if (32'(bus.hsize) > LaneBits) begin
      req_err = 1'b1;
    end
    if ((req_off & size_mask) != '0) begin
      req_err = 1'b1;
    end
    if (req_word_full >= ADDR_WIDTH'(MEM_DEPTH)) begin
      req_err = 1'b1;
    end
    for (int unsigned i = 0; i < NumBytes; i++) begin
      req_win[i] = (i >= 32'(req_off)) && (i < 32'(req_off) + (32'd1 << bus.hsize));
    end
  end

  always_comb begin
    ready_state = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    accept      = ready_state && bus.hselx && bus.hready && bus.htrans[1];
    ok_dest     = (WAIT_STATES > 0) ? StWait : StData;
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    write_d     = write_q;
    win_d       = win_q;
    unique case (state_q)
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1: state_d = StErr2;
      default: begin
        // Idle, Data and Err2 all leave the bus ready, so a new address may chain in.
        state_d = StIdle;
        if (accept) begin
          state_d = req_err ? StErr1 : ok_dest;
          cnt_d   = WaitInit;
          word_d  = req_word;
          write_d = bus.hwrite;
          win_d   = req_win;
        end
      end
    endcase
  end

  // Write merge and read capture; a read landing on the word being written
  // this edge sees the merged value.
  always_comb begin
    commit  = (state_q == StData) && write_q;
    wr_word = mem_q[word_q];
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (bus.hwstrb[i] && win_q[i]) begin
        wr_word[8*i +: 8] = bus.hwdata[8*i +: 8];
      end
    end
    rd_idx  = accept ? req_word : word_q;
    rd_word = (commit && (rd_idx == word_q)) ? wr_word : mem_q[rd_idx];
    rdata_d = '0;
    if ((state_d == StData) && !write_d) begin
      rdata_d = rd_word;
    end
  end

  always_comb begin
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    unique case (state_q)
      StWait: bus.hreadyout = 1'b0;
      StErr1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
      end
      StErr2: bus.hresp = 1'b1;
      default: ;
    endcase
    bus.hrdata = rdata_q;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      write_q <= 1'b0;
      win_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      write_q <= write_d;
      win_q   <= win_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      mem_q[word_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Randomized bench for ahb_slave_responder: two instances (0 and 2 wait states),
// each compared cycle by cycle against a transfer-level reference model.
module tb_ahb_slave_responder;

  typedef struct {
    int          kind;   // 0 normal, 2 hready forced low, 3 reset during its data phase
    bit          hsel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    bit          wr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  burst;
  } op_t;

  localparam logic [1:0] TrIdle = 2'b00;
  localparam logic [1:0] TrNseq = 2'b10;
  localparam logic [1:0] TrSeq  = 2'b11;

  logic        hclk;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic check_eq(input int cfg, input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %h, want %h", cfg, tag, got, exp);
    end
  endtask

  function automatic op_t mk(input int kind, input bit hsel, input logic [1:0] tr,
                             input logic [31:0] a, input logic [2:0] sz, input bit wr,
                             input logic [31:0] d, input logic [3:0] st,
                             input logic [2:0] bu);
    op_t o;
    o.kind = kind; o.hsel = hsel; o.trans = tr; o.addr = a; o.size = sz;
    o.wr = wr; o.data = d; o.strb = st; o.burst = bu;
    return o;
  endfunction

  function automatic bit mdl_err(input logic [31:0] a, input logic [2:0] sz);
    int unsigned nb;
    nb = 32'd1 << sz;
    return (nb > 4) || ((a % nb) != 0) || ((a / 4) >= 256);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int unsigned Ws = (g == 0) ? 0 : 2;
    logic rst_n;
    logic hready_ovr;
    bit   done_g;
    logic [31:0] mdl_mem [256];

    ahb_slave_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();
    assign bus_if.hready = bus_if.hreadyout & ~hready_ovr;

    ahb_slave_responder #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (256),
      .WAIT_STATES(Ws)
    ) u_dut (
      .hclk   (hclk),
      .hresetn(rst_n),
      .bus    (bus_if)
    );

    initial begin : run
      op_t         ops[$];
      op_t         cur, o, idle_op;
      bit          act, perr, pwr, consumed, pend_rst, acc, exp_rdy, exp_resp;
      int          left, cyc;
      int unsigned word, off, nb, r;
      logic [31:0] paddr, pdata, exp_rd;
      logic [2:0]  psize;
      logic [3:0]  pstrb;

      idle_op = mk(0, 1'b0, TrIdle, 32'h0, 3'd2, 1'b0, 32'h0, 4'h0, 3'd0);

      // Directed sequences first.
      ops.push_back(mk(0, 1, TrNseq, 32'h10, 3'd2, 1, 32'hDEADBEEF, 4'hF, 3'd0));
      ops.push_back(mk(0, 1, TrNseq, 32'h10, 3'd2, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(idle_op);
      ops.push_back(mk(0, 1, TrNseq, 32'h04, 3'd2, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(idle_op);
      ops.push_back(mk(0, 1, TrNseq, 32'h400, 3'd2, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(mk(0, 1, TrNseq, 32'h10, 3'd2, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(idle_op);
      ops.push_back(mk(0, 1, TrNseq, 32'h404, 3'd2, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(mk(0, 1, TrIdle, 32'h404, 3'd2, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(idle_op);
      ops.push_back(mk(0, 1, TrNseq, 32'h20, 3'd2, 1, 32'h11223344, 4'hF, 3'd0));
      ops.push_back(mk(0, 1, TrNseq, 32'h03, 3'd1, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(mk(0, 1, TrNseq, 32'h21, 3'd0, 1, 32'hAAAAAAAA, 4'hF, 3'd0));
      ops.push_back(mk(0, 1, TrNseq, 32'h20, 3'd2, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(mk(0, 1, TrNseq, 32'h00, 3'd3, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(idle_op);
      for (int i = 0; i < 4; i++) begin
        ops.push_back(mk(0, 1, (i == 0) ? TrNseq : TrSeq, 32'(4 * i), 3'd2, 1, $urandom,
                         4'hF, 3'd3));
      end
      for (int i = 0; i < 4; i++) begin
        ops.push_back(mk(0, 1, (i == 0) ? TrNseq : TrSeq, 32'(4 * i), 3'd2, 0, 32'h0,
                         4'h0, 3'd3));
      end
      ops.push_back(idle_op);
      ops.push_back(mk(2, 1, TrNseq, 32'h10, 3'd2, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(idle_op);
      ops.push_back(mk(0, 1, TrNseq, 32'h30, 3'd2, 1, 32'h55AA55AA, 4'hF, 3'd0));
      ops.push_back(idle_op);
      ops.push_back(mk(3, 1, TrNseq, 32'h30, 3'd2, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(mk(0, 1, TrNseq, 32'h30, 3'd2, 0, 32'h0, 4'h0, 3'd0));
      ops.push_back(idle_op);

      for (int i = 0; i < 300; i++) begin
        o.kind  = ($urandom_range(0, 29) == 0) ? 2 : 0;
        o.hsel  = ($urandom_range(0, 7) != 0);
        o.trans = 2'($urandom_range(0, 3));
        o.wr    = 1'($urandom_range(0, 1));
        r       = $urandom_range(0, 9);
        o.size  = (r < 5) ? 3'd2 : (r < 7) ? 3'd1 : (r < 9) ? 3'd0 : 3'd3;
        nb      = 32'd1 << o.size;
        word    = ($urandom_range(0, 19) == 0) ? 256 + $urandom_range(0, 200)
                                                : $urandom_range(0, 15);
        off     = $urandom_range(0, 3);
        if ($urandom_range(0, 9) != 0) off = off - (off % nb);
        o.addr  = 32'(word * 4 + off);
        o.data  = $urandom;
        o.strb  = 4'($urandom_range(0, 15));
        o.burst = 3'($urandom_range(0, 7));
        ops.push_back(o);
      end

      rst_n             = 1'b0;
      hready_ovr        = 1'b0;
      bus_if.hselx      = 1'b0;
      bus_if.haddr      = '0;
      bus_if.htrans     = TrIdle;
      bus_if.hwrite     = 1'b0;
      bus_if.hsize      = 3'd2;
      bus_if.hburst     = 3'd0;
      bus_if.hwdata     = '0;
      bus_if.hwstrb     = '0;
      for (int i = 0; i < 256; i++) mdl_mem[i] = '0;

      @(negedge hclk);
      check_eq(g, "reset_hreadyout", 32'(bus_if.hreadyout), 32'd1);
      check_eq(g, "reset_hresp", 32'(bus_if.hresp), 32'd0);
      check_eq(g, "reset_hrdata", bus_if.hrdata, 32'd0);
      rst_n = 1'b1;

      act = 0; perr = 0; pwr = 0; left = 0; consumed = 1; pend_rst = 0;
      paddr = '0; pdata = '0; psize = '0; pstrb = '0;
      cur = idle_op;
      cyc = 0;
      while ((ops.size() > 0 || act || !consumed) && cyc < 5000) begin
        @(negedge hclk);
        cyc++;
        if (pend_rst && act) begin
          rst_n = 1'b0;
          #1;
          check_eq(g, "async_rst_hreadyout", 32'(bus_if.hreadyout), 32'd1);
          check_eq(g, "async_rst_hresp", 32'(bus_if.hresp), 32'd0);
          check_eq(g, "async_rst_hrdata", bus_if.hrdata, 32'd0);
          #1 rst_n = 1'b1;
          for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
          act = 0; consumed = 1; pend_rst = 0;
        end

        exp_rdy  = !act || (left == 1);
        exp_resp = act && perr;
        exp_rd   = (act && !perr && !pwr && left == 1) ? mdl_mem[paddr[9:2]] : 32'h0;
        check_eq(g, "hreadyout", 32'(bus_if.hreadyout), 32'(exp_rdy));
        check_eq(g, "hresp", 32'(bus_if.hresp), 32'(exp_resp));
        check_eq(g, "hrdata", bus_if.hrdata, exp_rd);

        if (consumed) begin
          cur = (ops.size() > 0) ? ops.pop_front() : idle_op;
          hready_ovr    = (cur.kind == 2);
          bus_if.hselx  = cur.hsel;
          bus_if.haddr  = cur.addr;
          bus_if.htrans = cur.trans;
          bus_if.hwrite = cur.wr;
          bus_if.hsize  = cur.size;
          bus_if.hburst = cur.burst;
        end
        if (act && pwr) begin
          bus_if.hwdata = pdata;
          bus_if.hwstrb = pstrb;
        end else begin
          bus_if.hwdata = $urandom;
          bus_if.hwstrb = 4'($urandom_range(0, 15));
        end

        // Advance the model across the coming rising edge.
        acc      = cur.hsel && cur.trans[1] && exp_rdy && !hready_ovr;
        consumed = exp_rdy;
        if (act && left > 1) begin
          left--;
        end else begin
          if (act && !perr && pwr) begin
            for (int b = 0; b < 4; b++) begin
              if (pstrb[b] && b >= int'(paddr[1:0]) && b < int'(paddr[1:0]) + (1 << psize))
                mdl_mem[paddr[9:2]][8*b +: 8] = pdata[8*b +: 8];
            end
          end
          act = 0;
          if (acc) begin
            act   = 1;
            perr  = mdl_err(cur.addr, cur.size);
            left  = perr ? 2 : int'(Ws) + 1;
            pwr   = cur.wr;
            paddr = cur.addr;
            psize = cur.size;
            pdata = cur.data;
            pstrb = cur.strb;
            if (cur.kind == 3) pend_rst = 1;
          end
        end
      end
      check_eq(g, "drained", 32'(act), 32'd0);
      done_g = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 20000; c++) begin
      @(posedge hclk);
      if (g_cfg[0].done_g && g_cfg[1].done_g) break;
    end
    check_eq(99, "all_done", {30'b0, g_cfg[1].done_g, g_cfg[0].done_g}, 32'h3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
